// File: rtl/pulse_timestamp_capture.sv
// Pulse timestamp capture: synchronises an asynchronous toggle line, detects
// each level change, and queues the coarse counter value at detection into a
// first-word-fall-through tag FIFO. Drops on a full FIFO are counted.
//
// state | meaning
// ------+---------------------------------------------------------------
// ARM   | post-reset settling; synchroniser still filling, detections ignored
// RUN   | detections with enable=1 are pushed (or counted as dropped when full)
module pulse_timestamp_capture #(
  parameter int CNT_WIDTH   = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          evt_toggle,
  input  logic                          enable,
  output logic [CNT_WIDTH-1:0]          tag_data,
  output logic                          tag_valid,
  input  logic                          tag_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ARM_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic {ARM, RUN} state_e;

  state_e                 state_q, state_d;
  logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
  logic [SYNC_STAGES-1:0] sync_chain_q;
  logic                   sync_q;
  logic                   prev_q;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [15:0]            ovf_q, ovf_d;
  logic                   evt_det, fifo_full, pop, capture, push, drop;

  assign sync_q    = sync_chain_q[SYNC_STAGES-1];
  assign evt_det   = sync_q ^ prev_q;
  assign fifo_full = (level_q == LVL_W'(FIFO_DEPTH));
  assign tag_valid = (level_q != '0);
  assign pop       = tag_valid & tag_ready;
  assign capture   = evt_det & (state_q == RUN) & enable;
  // A full FIFO can still take the event when the head leaves in the same cycle.
  assign push      = capture & (~fifo_full | pop);
  assign drop      = capture & fifo_full & ~pop;

  assign tag_data       = tag_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level     = level_q;
  assign overflow_count = ovf_q;

  // Synchroniser and edge history run through reset so a static level never looks like an event.
  always_ff @(posedge clk) begin
    sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], evt_toggle};
    prev_q       <= sync_q;
  end

  // ARM/RUN next state; arm timer counts down the synchroniser fill time.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    if (state_q == ARM) begin
      if (arm_cnt_q == '0) state_d = RUN;
      else                 arm_cnt_d = arm_cnt_q - ARM_W'(1);
    end
  end

  // FIFO pointer, occupancy, drop counter and coarse counter next values.
  always_comb begin
    cnt_d    = cnt_q + CNT_WIDTH'(1);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);
    ovf_d = ovf_q;
    if (drop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARM;
      arm_cnt_q <= ARM_W'(SYNC_STAGES);
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
    end
  end

  // Tag storage; contents are meaningless until covered by the occupancy count.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= cnt_q;
  end

endmodule

// File: tb/tb_pulse_timestamp_capture.sv
// Directed bench for pulse_timestamp_capture: a table of burst scenarios plus
// hand-written sequences for latency, full-with-pop, ARM, reset and wrap.
module tb_pulse_timestamp_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        evt_toggle;
  logic        enable;
  logic        tag_ready;
  logic [31:0] tag_data;
  logic        tag_valid;
  logic [3:0]  fifo_level;
  logic [15:0] overflow_count;

  logic [7:0]  s_tag_data;
  logic        s_tag_valid;
  logic [3:0]  s_fifo_level;
  logic [15:0] s_overflow_count;

  pulse_timestamp_capture #(.CNT_WIDTH(32), .FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .evt_toggle(evt_toggle), .enable(enable),
    .tag_data(tag_data), .tag_valid(tag_valid), .tag_ready(tag_ready),
    .fifo_level(fifo_level), .overflow_count(overflow_count));

  pulse_timestamp_capture #(.CNT_WIDTH(8), .FIFO_DEPTH(8), .SYNC_STAGES(2)) dut_s (
    .clk(clk), .rst(rst), .evt_toggle(evt_toggle), .enable(enable),
    .tag_data(s_tag_data), .tag_valid(s_tag_valid), .tag_ready(tag_ready),
    .fifo_level(s_fifo_level), .overflow_count(s_overflow_count));

  always #5 clk = ~clk;

  // Reference coarse counter.
  logic [31:0] cnt_m = '0;
  always @(posedge clk) begin
    if (rst) cnt_m <= '0;
    else     cnt_m <= cnt_m + 32'd1;
  end

  typedef struct {
    int n;
    int sp;
    bit en;
    int exp_level;
    int exp_ovf;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] stamps[$];
  logic [31:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic reset_arm();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
  endtask

  // Toggle now; detection happens two edges later, so that counter value is the tag.
  task automatic toggle_evt();
    evt_toggle = ~evt_toggle;
    stamps.push_back(cnt_m + 32'd2);
  endtask

  task automatic drain(input string nm, input int n);
    for (int k = 0; k < n; k++) begin
      chk({nm, "_valid"}, {31'd0, tag_valid}, 32'd1);
      chk({nm, "_data"}, tag_data, exp_q[k]);
      tag_ready = 1'b1;
      tick();
    end
    tag_ready = 1'b0;
    chk({nm, "_empty"}, {28'd0, fifo_level}, 32'd0);
  endtask

  initial begin
    int guard;
    bit ok;
    logic [31:0] new_stamp;

    vecs[0] = '{n: 10, sp: 4, en: 1'b1, exp_level: 8, exp_ovf: 2};
    vecs[1] = '{n: 3,  sp: 4, en: 1'b0, exp_level: 0, exp_ovf: 0};
    vecs[2] = '{n: 1,  sp: 2, en: 1'b1, exp_level: 1, exp_ovf: 0};
    vecs[3] = '{n: 8,  sp: 1, en: 1'b1, exp_level: 8, exp_ovf: 0};
    vecs[4] = '{n: 12, sp: 3, en: 1'b1, exp_level: 8, exp_ovf: 4};

    rst = 1'b1; evt_toggle = 1'b0; enable = 1'b1; tag_ready = 1'b0;
    repeat (3) tick();
    chk("rst_level", {28'd0, fifo_level}, 32'd0);
    chk("rst_valid", {31'd0, tag_valid}, 32'd0);
    chk("rst_data", tag_data, 32'd0);
    chk("rst_ovf", {16'd0, overflow_count}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      reset_arm();
      stamps.delete();
      enable = vecs[i].en;
      for (int j = 0; j < vecs[i].n; j++) begin
        toggle_evt();
        repeat (vecs[i].sp) tick();
      end
      repeat (6) tick();
      chk($sformatf("vec%0d_level", i), {28'd0, fifo_level}, vecs[i].exp_level);
      chk($sformatf("vec%0d_ovf", i), {16'd0, overflow_count}, vecs[i].exp_ovf);
      exp_q.delete();
      for (int k = 0; k < vecs[i].exp_level; k++) exp_q.push_back(stamps[k]);
      drain($sformatf("vec%0d", i), vecs[i].exp_level);
      enable = 1'b1;
    end

    // Latency: toggle with counter 0x10 at the sampling edge.
    reset_arm();
    guard = 0;
    while (cnt_m != 32'h10 && guard < 1000) begin
      tick();
      guard++;
    end
    if (guard >= 1000) chk("lat_wait_timeout", 32'd1, 32'd0);
    evt_toggle = ~evt_toggle;
    tick();
    chk("lat_edge1_valid", {31'd0, tag_valid}, 32'd0);
    tick();
    chk("lat_edge2_valid", {31'd0, tag_valid}, 32'd0);
    tick();
    chk("lat_edge3_valid", {31'd0, tag_valid}, 32'd1);
    chk("lat_edge3_level", {28'd0, fifo_level}, 32'd1);
    chk("lat_edge3_data", tag_data, 32'h12);

    // Full FIFO: push and pop land in the same cycle.
    reset_arm();
    stamps.delete();
    for (int j = 0; j < 8; j++) begin
      toggle_evt();
      repeat (4) tick();
    end
    repeat (4) tick();
    chk("fullpop_pre_level", {28'd0, fifo_level}, 32'd8);
    new_stamp = cnt_m + 32'd2;
    evt_toggle = ~evt_toggle;
    tick();
    tick();
    tag_ready = 1'b1;
    tick();
    tag_ready = 1'b0;
    chk("fullpop_level", {28'd0, fifo_level}, 32'd8);
    chk("fullpop_ovf", {16'd0, overflow_count}, 32'd0);
    exp_q.delete();
    for (int k = 1; k < 8; k++) exp_q.push_back(stamps[k]);
    exp_q.push_back(new_stamp);
    drain("fullpop", 8);

    // A toggle right at reset release is detected while still in ARM.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    evt_toggle = ~evt_toggle;
    repeat (8) tick();
    chk("arm_suppress_level", {28'd0, fifo_level}, 32'd0);

    // Reset mid-operation discards contents and drop count.
    reset_arm();
    for (int j = 0; j < 10; j++) begin
      evt_toggle = ~evt_toggle;
      tick();
    end
    repeat (4) tick();
    chk("midrst_pre_ovf", {16'd0, overflow_count}, 32'd2);
    rst = 1'b1;
    tick();
    chk("midrst_level", {28'd0, fifo_level}, 32'd0);
    chk("midrst_valid", {31'd0, tag_valid}, 32'd0);
    chk("midrst_ovf", {16'd0, overflow_count}, 32'd0);
    chk("midrst_data", tag_data, 32'd0);

    // Static high through reset, then 100 quiet cycles with tag_ready held.
    evt_toggle = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    tag_ready = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (fifo_level != 4'd0 || tag_valid != 1'b0) ok = 1'b0;
    end
    tag_ready = 1'b0;
    chk("static_high_quiet", {31'd0, ok}, 32'd1);

    // Counter wrap on the 8-bit instance: tags 0xFF then 0x01.
    reset_arm();
    guard = 0;
    while (cnt_m[7:0] != 8'hFD && guard < 1000) begin
      tick();
      guard++;
    end
    if (guard >= 1000) chk("wrap_wait_timeout", 32'd1, 32'd0);
    evt_toggle = ~evt_toggle;
    tick();
    tick();
    evt_toggle = ~evt_toggle;
    repeat (6) tick();
    chk("wrap_level", {28'd0, s_fifo_level}, 32'd2);
    chk("wrap_tag0", {24'd0, s_tag_data}, 32'hFF);
    tag_ready = 1'b1;
    tick();
    tag_ready = 1'b0;
    chk("wrap_tag1", {24'd0, s_tag_data}, 32'h01);
    tag_ready = 1'b1;
    tick();
    tag_ready = 1'b0;
    chk("wrap_empty", {31'd0, s_tag_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_timestamp_capture.md
PULSE_TIMESTAMP_CAPTURE -- requirements
Module: pulse_timestamp_capture

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 32, meaning the width of the coarse timestamp counter and tag word.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the tag FIFO depth in entries; it is a power of 2 and at least 2.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on evt_toggle; it is at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port evt_toggle, input, 1 bit: asynchronous toggle from the upstream pulse generator's flip-flop Q; each level change is one event.
REQ-007 The block SHALL have port enable, input, 1 bit: when high, detected events are captured.
REQ-008 The block SHALL have port tag_data, output, CNT_WIDTH bits: the timestamp at the FIFO head.
REQ-009 The block SHALL have port tag_valid, output, 1 bit: asserted when the FIFO is not empty.
REQ-010 The block SHALL have port tag_ready, input, 1 bit: consumer accept.
REQ-011 The block SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-012 The block SHALL have port overflow_count, output, 16 bits: the number of events dropped because the FIFO was full.

Function
REQ-013 The coarse counter SHALL increment by 1 every clk cycle while not in reset and wrap from 2^CNT_WIDTH-1 to 0.
REQ-014 evt_toggle SHALL pass through a chain of SYNC_STAGES flops; the last stage is sync_q.
REQ-015 An event SHALL be detected in any cycle where sync_q differs from the registered previous value prev_q, and prev_q SHALL update to sync_q every cycle.
REQ-016 The timestamp stored for an event SHALL be the coarse counter value in the cycle the event is detected.
REQ-017 Latency SHALL be exactly SYNC_STAGES+1 clk edges from the first edge sampling the new evt_toggle level to the edge at which tag_valid and fifo_level reflect the push.
REQ-018 The FSM SHALL have states ARM and RUN and SHALL enter ARM on reset.
REQ-019 In ARM, detections SHALL be suppressed; the FSM SHALL move to RUN after SYNC_STAGES+1 cycles with rst low.
REQ-020 In RUN, a detected event with enable=1 SHALL be pushed if the FIFO is not full, or if a pop occurs in the same cycle.
REQ-021 A detected event with enable=1 while the FIFO is full and no pop occurs SHALL be dropped, and overflow_count SHALL increment, saturating at 0xFFFF.
REQ-022 A detected event with enable=0 SHALL be discarded without incrementing overflow_count.
REQ-023 The FIFO SHALL be first-word-fall-through: tag_data SHALL equal the oldest entry whenever tag_valid=1 and SHALL hold stable until the pop.
REQ-024 A pop SHALL occur when tag_valid && tag_ready; tag_ready while empty SHALL have no effect.
REQ-025 A simultaneous push and pop SHALL leave fifo_level unchanged and preserve order.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH, and fifo_level SHALL range from 0 to FIFO_DEPTH.
REQ-027 At most one event SHALL be detected per cycle; toggles faster than one level change per clk are outside the contract.

Reset
REQ-028 While rst=1, the counter, fifo_level, read and write pointers, and overflow_count SHALL be 0; tag_valid SHALL be 0; tag_data SHALL be 0; and the FSM SHALL be in ARM.
REQ-029 While rst=1, the synchronizer flops SHALL keep sampling, and prev_q SHALL load sync_q so that a static high evt_toggle produces no event after reset.
REQ-030 Reset asserted mid-operation SHALL discard all FIFO contents and the overflow count at the next clk edge.

Verification
REQ-031 evt_toggle held at 1 through reset, then released -> no push; fifo_level=0 and tag_valid=0 for 100 cycles.
REQ-032 Toggle evt_toggle once with counter at 0x00000010 at the sampling edge (SYNC_STAGES=2) -> tag_valid rises 3 edges later with tag_data=0x00000012.
REQ-033 10 toggles spaced 4 cycles apart, tag_ready=0, FIFO_DEPTH=8 -> fifo_level=8, overflow_count=2, and entries are the first 8 timestamps in order, 4 apart.
REQ-034 FIFO full with tag_ready=1 and an event in the same cycle -> fifo_level stays 8, overflow_count unchanged, and the new timestamp appears last.
REQ-035 enable=0 with 3 toggles -> fifo_level=0 and overflow_count=0.
REQ-036 Counter preloaded by running to 0xFFFFFFFE with an event spanning the wrap -> tags 0xFFFFFFFF and 0x00000001 are captured in order.
